svc_axi_mem_resp: RTL and testbench
===================================

# svc_axi_mem_resp

AXI4 subordinate that answers INCR bursts from an internal word array, so memory-test initiators (striped or single-port) can run write-then-readback traffic without an SRAM controller or pin model behind them. It sits where an SRAM controller's AXI subordinate port would normally connect. It accepts, stores and returns burst data, and generates B/R responses with IDs and LAST.

## Interface
- AXI_ADDR_WIDTH, 20, byte address width
- AXI_DATA_WIDTH, 16, data width; power of two, ≥8
- AXI_ID_WIDTH, 4, transaction ID width
- MEM_DEPTH_BITS, 8, log2 of array depth in data words
- clk  in  1  clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- s_axi_awvalid/awready  in/out  1  AW handshake
- s_axi_awaddr/awid/awlen/awsize/awburst  in  ADDR/ID/8/3/2  write address
- s_axi_wvalid/wready  in/out  1  W handshake
- s_axi_wdata/wstrb/wlast  in  DATA/DATA÷8/1  write beat
- s_axi_bvalid/bready  out/in  1  B handshake
- s_axi_bid/bresp  out  ID/2  write response
- s_axi_arvalid/arready  in/out  1  AR handshake
- s_axi_araddr/arid/arlen/arsize/arburst  in  ADDR/ID/8/3/2  read address
- s_axi_rvalid/rready  out/in  1  R handshake
- s_axi_rid/rdata/rresp/rlast  out  ID/DATA/2/1  read beat

## Operation
- Word index = addr[MEM_DEPTH_BITS+B-1:B], B = log2(AXI_DATA_WIDTH/8); higher address bits ignored; index wraps modulo 2^MEM_DEPTH_BITS inside a burst.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE. W_IDLE: awready=1; AW handshake latches id, index, beats = awlen+1, error flag. W_DATA: wready=1; each handshake writes the bytes enabled by wstrb, index+1, beats-1. The burst ends on the (awlen+1)th beat regardless of wlast. W_RESP: bvalid=1 until bready.
- Write error: burst≠INCR or awsize≠B → beats consumed but not stored, bresp=SLVERR(2'b10). wlast disagreeing with beat count → bresp=SLVERR, data still stored. Otherwise OKAY.
- Read FSM: R_IDLE → R_DATA → R_IDLE. R_IDLE: arready=1; AR handshake latches id, index, beats. R_DATA: rvalid=1. rdata, rid, rlast and rresp stay stable until rready. rlast=1 on the final beat only.
- Read error: burst≠INCR or arsize≠B → every beat rdata=0, rresp=SLVERR; beat count honoured.
- Read and write channels are fully independent and may run concurrently.
- The array is not reset; contents survive rst_n.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bresp=rresp=0, rdata=0, bid=rid=0. awready and arready rise on the first clk after rst_n deasserts.
- AW handshake at cycle N: wready=1 at N+1. The last W handshake at M gives bvalid=1 at M+1. The next awready follows at the cycle after the B handshake.
- AR handshake at N: first rvalid at N+1 with registered data. Under rready=1, one beat per cycle, no bubbles. The final beat's handshake returns to R_IDLE (arready=1) the next cycle.
- Same-cycle write and read-beat load to one index: R returns the old data (read-before-write).
- rst_n asserted mid-burst: both FSMs go to IDLE immediately, valids drop, and the partial burst is abandoned with no response.

## Configuration
- SVC_AXI_MEM_RESP_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1) gates wready and rvalid. In W_DATA/R_DATA, each is forced low on cycles where lfsr[0]=1, to stress initiator backpressure. Once rvalid is asserted it does not drop until the handshake; the gate applies only to raising it. Outputs stay protocol-legal.
- Undefined: no LFSR logic; full throughput per Timing.

## Structure
- Package svc_axi_mem_resp_pkg: resp codes (OKAY, SLVERR), burst type INCR constant, write/read state enums.
- One sub-module, svc_axi_mem_resp_lfsr, instantiated only under SVC_AXI_MEM_RESP_STALL_EN. The array is an inferred register/BRAM in the top module.

## Test plan
- Write 4 beats INCR at addr 0x0010, id 3, data 0x1111..0x4444, then read the same → bid=3, bresp=0; R beats 0x1111,0x2222,0x3333,0x4444; rlast only on beat 4; rid=3.
- 256-beat write from index 0xFE, then read it back → wrap to indices 0xFE,0xFF,0x00…; data matches, with no bubbles at rready=1.
- wstrb=2'b01 writing 0xABCD over 0x1234 → readback 0x12CD.
- awburst=FIXED, 2 beats → bresp=SLVERR, memory unchanged; arburst=WRAP, 2 beats → two beats with rdata=0, rresp=SLVERR, rlast on the second.
- rready toggling 1,0,0,1 during a 4-beat read → rdata/rlast held while stalled; all beats in order. With the macro defined, same data integrity under random stalls.
- rst_n pulsed during W_DATA beat 2 of 8 → no bvalid; awready=1 on the cycle after release; a subsequent 1-beat write/read succeeds.

Source files
------------

// File: rtl/svc_axi_mem_resp_pkg.sv
// svc_axi_mem_resp_pkg: response codes, burst type and FSM state types shared by the memory responder.
package svc_axi_mem_resp_pkg;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
endpackage

// File: rtl/svc_axi_mem_resp_lfsr.sv
// svc_axi_mem_resp_lfsr: 16-bit Fibonacci LFSR whose low bit requests a backpressure stall.
module svc_axi_mem_resp_lfsr
    import svc_axi_mem_resp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic o_stall
);
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_lfsr <= LFSR_SEED;
        else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end

    assign o_stall = r_lfsr[0];
endmodule

// File: rtl/svc_axi_mem_resp.sv
// svc_axi_mem_resp: AXI4 INCR-burst subordinate backed by an internal word array.
// Define SVC_AXI_MEM_RESP_STALL_EN to gate wready/rvalid with an LFSR for backpressure stress.
module svc_axi_mem_resp
    import svc_axi_mem_resp_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast
);
    localparam int         B    = $clog2(AXI_DATA_WIDTH / 8);
    localparam int         NB   = AXI_DATA_WIDTH / 8;
    localparam logic [2:0] SIZE = 3'(B);

    logic [AXI_DATA_WIDTH-1:0] r_mem [2**MEM_DEPTH_BITS];
    w_state_t                  r_wstate;
    r_state_t                  r_rstate;
    logic [MEM_DEPTH_BITS-1:0] r_widx, r_ridx, w_awidx, w_aridx;
    logic [7:0]                r_wleft, r_rleft;
    logic                      r_wdrop, r_wlerr, r_rerr;
    logic                      w_stall, w_whs, w_arerr, w_unused;

    assign w_awidx  = s_axi_awaddr[MEM_DEPTH_BITS+B-1:B];
    assign w_aridx  = s_axi_araddr[MEM_DEPTH_BITS+B-1:B];
    assign w_whs    = (r_wstate == W_DATA) && s_axi_wvalid && s_axi_wready;
    assign w_arerr  = (s_axi_arburst != BURST_INCR) || (s_axi_arsize != SIZE);
    assign w_unused = &{1'b0, s_axi_awaddr, s_axi_araddr};

`ifdef SVC_AXI_MEM_RESP_STALL_EN
    svc_axi_mem_resp_lfsr u_lfsr (.clk(clk), .rst_n(rst_n), .o_stall(w_stall));
`else
    assign w_stall = 1'b0;
`endif

    // Array has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_whs && !r_wdrop)
            for (int i = 0; i < NB; i++)
                if (s_axi_wstrb[i]) r_mem[r_widx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate      <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_bid     <= '0;
            r_widx        <= '0;
            r_wleft       <= '0;
            r_wdrop       <= 1'b0;
            r_wlerr       <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awvalid && s_axi_awready) begin
                        r_wstate      <= W_DATA;
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= ~w_stall;
                        s_axi_bid     <= s_axi_awid;
                        r_widx        <= w_awidx;
                        r_wleft       <= s_axi_awlen;
                        r_wdrop       <= (s_axi_awburst != BURST_INCR) || (s_axi_awsize != SIZE);
                        r_wlerr       <= 1'b0;
                    end
                end
                W_DATA: begin
                    s_axi_wready <= ~w_stall;
                    if (w_whs) begin
                        r_widx  <= r_widx + 1'b1;
                        r_wleft <= r_wleft - 1'b1;
                        // Beat count, not wlast, ends the burst; a disagreeing wlast only flags SLVERR.
                        if (r_wleft == 8'd0) begin
                            r_wstate     <= W_RESP;
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bresp  <= (r_wdrop || r_wlerr || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                        end else if (s_axi_wlast) begin
                            r_wlerr <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (s_axi_bready) begin
                        r_wstate      <= W_IDLE;
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate      <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rdata   <= '0;
            s_axi_rid     <= '0;
            r_ridx        <= '0;
            r_rleft       <= '0;
            r_rerr        <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arvalid && s_axi_arready) begin
                        r_rstate      <= R_DATA;
                        s_axi_arready <= 1'b0;
                        s_axi_rid     <= s_axi_arid;
                        s_axi_rdata   <= w_arerr ? '0 : r_mem[w_aridx];
                        s_axi_rresp   <= w_arerr ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rlast   <= s_axi_arlen == 8'd0;
                        s_axi_rvalid  <= ~w_stall;
                        r_rerr        <= w_arerr;
                        r_ridx        <= w_aridx + 1'b1;
                        r_rleft       <= s_axi_arlen;
                    end
                end
                default: begin
                    if (s_axi_rvalid && s_axi_rready) begin
                        if (s_axi_rlast) begin
                            r_rstate      <= R_IDLE;
                            s_axi_rvalid  <= 1'b0;
                            s_axi_rlast   <= 1'b0;
                            s_axi_arready <= 1'b1;
                        end else begin
                            s_axi_rdata  <= r_rerr ? '0 : r_mem[r_ridx];
                            s_axi_rlast  <= r_rleft == 8'd1;
                            s_axi_rvalid <= ~w_stall;
                            r_ridx       <= r_ridx + 1'b1;
                            r_rleft      <= r_rleft - 1'b1;
                        end
                    end else if (!s_axi_rvalid) begin
                        s_axi_rvalid <= ~w_stall;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_svc_axi_mem_resp.sv
// tb_svc_axi_mem_resp: randomized write/readback bench for svc_axi_mem_resp against an array model.
// Honours SVC_AXI_MEM_RESP_STALL_EN by skipping exact-latency checks when stalls are enabled.
module tb_svc_axi_mem_resp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [19:0] awaddr, araddr;
    logic [3:0]  awid, arid, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp, wstrb;
    logic [15:0] wdata, rdata;

    logic [15:0] mem_m [256];
    logic [15:0] wd [256];
    logic [1:0]  ws [256];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    svc_axi_mem_resp dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr), .s_axi_awid(awid),
        .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_wlast(wlast), .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid),
        .s_axi_bresp(bresp), .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Burst of len+1 beats from wd/ws; wlast driven on beat lastb.
    task automatic axi_wr(input logic [19:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int lastb);
        int  n;
        bit  ok = 1;
        bit  store = (burst == 2'b01) && (size == 3'd1);
        int  idx = int'(addr[8:1]);
        @(negedge clk);
        awvalid = 1; awaddr = addr; awid = id; awlen = 8'(len); awsize = size; awburst = burst;
        n = 0;
        while (!awready && n < 1000) begin @(negedge clk); n++; end
        ok &= n < 1000;
        @(negedge clk);
        awvalid = 0;
`ifndef SVC_AXI_MEM_RESP_STALL_EN
        chk("w_lat", wready, 1);
`endif
        for (int i = 0; i <= len; i++) begin
            wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == lastb);
            n = 0;
            while (!wready && n < 1000) begin @(negedge clk); n++; end
            ok &= n < 1000;
            @(negedge clk);
        end
        wvalid = 0; wlast = 0;
`ifndef SVC_AXI_MEM_RESP_STALL_EN
        chk("b_lat", bvalid, 1);
`endif
        bready = 1;
        n = 0;
        while (!bvalid && n < 1000) begin @(negedge clk); n++; end
        ok &= n < 1000;
        chk("bid", bid, id);
        chk("bresp", bresp, (store && lastb == len) ? 2'b00 : 2'b10);
        @(negedge clk);
        bready = 0;
        chk("aw_ret", awready, 1);
        chk("w_timeout", ok, 1);
        if (store)
            for (int i = 0; i <= len; i++)
                for (int b = 0; b < 2; b++)
                    if (ws[i][b]) mem_m[(idx + i) % 256][8*b +: 8] = wd[i][8*b +: 8];
    endtask

    // mode 0: rready held high, 1: random rready, 2: rready 1,0,0,1 then high.
    task automatic axi_rd(input logic [19:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input logic [2:0] size, input int mode);
        int          n, beat, cyc;
        bit          held = 0;
        bit          rr, hl;
        logic [15:0] hd, e;
        logic [3:0]  pat = 4'b1001;
        bit          err = (burst != 2'b01) || (size != 3'd1);
        int          idx = int'(addr[8:1]);
        @(negedge clk);
        arvalid = 1; araddr = addr; arid = id; arlen = 8'(len); arsize = size; arburst = burst;
        n = 0;
        while (!arready && n < 1000) begin @(negedge clk); n++; end
        chk("ar_timeout", n < 1000, 1);
        @(negedge clk);
        arvalid = 0;
        beat = 0; cyc = 0;
        while (beat <= len && cyc < 4000) begin
            rr = (mode == 0) ? 1'b1 : (mode == 2) ? ((cyc < 4) ? pat[3 - cyc] : 1'b1) : 1'($urandom_range(0, 1));
            rready = rr;
            if (held) chk("r_hold", {rvalid, rlast, rdata}, {1'b1, hl, hd});
            if (rvalid) begin
                if (rr) begin
                    e = err ? 16'h0 : mem_m[(idx + beat) % 256];
                    chk("rdata", rdata, e);
                    chk("rlast", rlast, beat == len);
                    chk("rid", rid, id);
                    chk("rresp", rresp, err ? 2'b10 : 2'b00);
                    beat++;
                    held = 0;
                end else begin
                    held = 1; hd = rdata; hl = rlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rready = 0;
        chk("r_timeout", cyc < 4000, 1);
`ifndef SVC_AXI_MEM_RESP_STALL_EN
        if (mode == 0) chk("r_nobubble", cyc, len + 1);
`endif
        chk("ar_ret", arready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] ia, ib;
        rst_n = 0; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0; wlast = 0;
        awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
        araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {awready, wready, arready}, 0);
        chk("rst_valid", {bvalid, rvalid, rlast}, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        chk("rst_data", {rdata, bid, rid}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("rel_awready", awready, 1);
        chk("rel_arready", arready, 1);

        for (int i = 0; i < 4; i++) begin wd[i] = 16'h1111 * 16'(i + 1); ws[i] = 2'b11; end
        axi_wr(20'h00010, 4'd3, 3, 2'b01, 3'd1, 3);
        axi_rd(20'h00010, 4'd3, 3, 2'b01, 3'd1, 0);

        for (int i = 0; i < 256; i++) begin wd[i] = 16'($urandom); ws[i] = 2'b11; end
        axi_wr(20'h001FC, 4'd5, 255, 2'b01, 3'd1, 255);
        axi_rd(20'h001FC, 4'd6, 255, 2'b01, 3'd1, 0);

        for (int i = 0; i < 4; i++) begin wd[i] = 16'h1111 * 16'(i + 1); ws[i] = 2'b11; end
        axi_wr(20'h00010, 4'd3, 3, 2'b01, 3'd1, 3);

        wd[0] = 16'h1234; ws[0] = 2'b11;
        axi_wr(20'h00040, 4'd1, 0, 2'b01, 3'd1, 0);
        wd[0] = 16'hABCD; ws[0] = 2'b01;
        axi_wr(20'h00040, 4'd2, 0, 2'b01, 3'd1, 0);
        axi_rd(20'h00040, 4'd2, 0, 2'b01, 3'd1, 0);
        chk("strb_merge", rdata, 16'h12CD);

        wd[0] = 16'hDEAD; wd[1] = 16'hBEEF; ws[0] = 2'b11; ws[1] = 2'b11;
        axi_wr(20'h00010, 4'd9, 1, 2'b00, 3'd1, 1);
        axi_wr(20'h00010, 4'd10, 1, 2'b01, 3'd0, 1);
        axi_rd(20'h00010, 4'd4, 3, 2'b01, 3'd1, 0);
        axi_rd(20'h00010, 4'd2, 1, 2'b10, 3'd1, 0);
        axi_rd(20'h00010, 4'd7, 3, 2'b01, 3'd1, 2);

        wd[0] = 16'h5A5A; wd[1] = 16'hA5A5;
        axi_wr(20'h00080, 4'd4, 1, 2'b01, 3'd1, 0);
        axi_rd(20'h00080, 4'd4, 1, 2'b01, 3'd1, 1);

        // Concurrent traffic: writes confined to indices 0..115, reads to 128..243.
        for (int t = 0; t < 30; t++) begin
            int wl = $urandom_range(0, 15);
            int rl = $urandom_range(0, 15);
            ia = 8'($urandom_range(0, 100));
            ib = 8'($urandom_range(128, 228));
            for (int i = 0; i <= wl; i++) begin wd[i] = 16'($urandom); ws[i] = 2'($urandom); end
            fork
                axi_wr({11'($urandom), ia, 1'($urandom)}, 4'($urandom), wl, 2'b01, 3'd1, wl);
                axi_rd({11'($urandom), ib, 1'($urandom)}, 4'($urandom), rl, 2'b01, 3'd1, 1);
            join
        end
        axi_rd(20'h00000, 4'd8, 127, 2'b01, 3'd1, 1);

        for (int i = 0; i < 8; i++) begin wd[i] = 16'h7000 + 16'(i); ws[i] = 2'b11; end
        @(negedge clk);
        awvalid = 1; awaddr = 20'h000C0; awid = 4'd11; awlen = 8'd7; awsize = 3'd1; awburst = 2'b01;
        n = 0;
        while (!awready && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        awvalid = 0;
        wvalid = 1; wdata = wd[0]; wstrb = 2'b11; wlast = 0;
        while (!wready && n < 2000) begin @(negedge clk); n++; end
        chk("rst_mid_setup", n < 2000, 1);
        @(negedge clk);
        wdata = wd[1];
        rst_n = 0;
        #1;
        chk("rst_mid_wready", wready, 0);
        chk("rst_mid_bvalid", bvalid, 0);
        wvalid = 0;
        mem_m[8'h60] = wd[0];
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_mid_awready", awready, 1);
        chk("rst_mid_nob", bvalid, 0);
        wd[0] = 16'hC0DE; ws[0] = 2'b11;
        axi_wr(20'h000C0, 4'd12, 0, 2'b01, 3'd1, 0);
        axi_rd(20'h000C0, 4'd12, 0, 2'b01, 3'd1, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
